// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV32 subset control FSM with memory-wait timeout and fault latch
module control_unit #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_alu_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_alu_a_sel,
    output logic [1:0] o_alu_b_sel,
    output logic [2:0] o_alu_op,
    output logic       o_pc_src,
    output logic       o_fw_sel,
    output logic [3:0] o_state,
    output logic [1:0] o_fault_code
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_WB_MEM    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_EXEC_LUI  = 4'd8;
    localparam logic [3:0] S_WB_ALU    = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_FAULT     = 4'd15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_SUM  = 3'd0;
    localparam logic [2:0] ALU_SHL  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_LOAD = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_AND  = 3'd7;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    localparam logic [7:0] W_LAST_WAIT = 8'(WAIT_LIMIT - 1);

    logic [3:0] r_state;
    logic [1:0] r_fault_code;
    logic [7:0] r_wait_cnt;

    logic [3:0] w_next_state;
    logic [1:0] w_next_fault;
    logic [3:0] w_decode_next;
    logic       w_f3_arith;
    logic       w_wait_state;
    logic       w_timeout;
    logic [2:0] w_mapped_op;

    assign w_f3_arith = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b101) ||
                        (i_funct3 == 3'b111);

    always_comb begin
        w_mapped_op = ALU_SUM;
        case (i_funct3)
            3'b001:  w_mapped_op = ALU_SHL;
            3'b100:  w_mapped_op = ALU_XOR;
            3'b101:  w_mapped_op = ALU_SHR;
            3'b111:  w_mapped_op = ALU_AND;
            default: w_mapped_op = ALU_SUM;
        endcase
    end

    // Opcode dispatch and legality are resolved together so any bad encoding lands in FAULT.
    always_comb begin
        w_decode_next = S_FAULT;
        case (i_opcode)
            OP_R: begin
                if (w_f3_arith && (!i_funct7_5 || i_funct3 == 3'b000))
                    w_decode_next = S_EXEC_R;
            end
            OP_I: begin
                if (w_f3_arith)
                    w_decode_next = S_EXEC_I;
            end
            OP_LOAD, OP_STORE: begin
                if (i_funct3 == 3'b010)
                    w_decode_next = S_MEM_ADDR;
            end
            OP_BRANCH: begin
                if (i_funct3 == 3'b000 || i_funct3 == 3'b001)
                    w_decode_next = S_BRANCH;
            end
            OP_LUI:  w_decode_next = S_EXEC_LUI;
            default: w_decode_next = S_FAULT;
        endcase
    end

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    assign w_timeout    = w_wait_state && !i_mem_ready && (r_wait_cnt == W_LAST_WAIT);

    always_comb begin
        w_next_state = r_state;
        w_next_fault = FC_NONE;
        case (r_state)
            S_FETCH:     w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_next_state = w_decode_next;
            S_MEM_ADDR: begin
                if (i_opcode == OP_LOAD)
                    w_next_state = S_MEM_READ;
                else if (i_opcode == OP_STORE)
                    w_next_state = S_MEM_WRITE;
                else
                    w_next_state = S_FAULT;
            end
            S_MEM_READ:  w_next_state = i_mem_ready ? S_WB_MEM : S_MEM_READ;
            S_WB_MEM:    w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = i_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next_state = S_WB_ALU;
            S_EXEC_I:    w_next_state = S_WB_ALU;
            S_EXEC_LUI:  w_next_state = S_WB_ALU;
            S_WB_ALU:    w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_FAULT: begin
                w_next_state = S_FAULT;
                w_next_fault = r_fault_code;
            end
            default:     w_next_state = S_FAULT;
        endcase
        if (w_timeout) begin
            w_next_state = S_FAULT;
            w_next_fault = FC_TIMEOUT;
        end else if (w_next_state == S_FAULT && r_state != S_FAULT) begin
            w_next_fault = FC_ILLEGAL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_FETCH;
            r_fault_code <= FC_NONE;
            r_wait_cnt   <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_next_fault;
            // Leaving a wait state always goes through mem_ready=1 or FAULT, so this also clears on entry.
            if (w_wait_state && !i_mem_ready)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        o_pc_write  = 1'b0;
        o_ir_write  = 1'b0;
        o_reg_write = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_alu_a_sel = 1'b0;
        o_alu_b_sel = 2'd0;
        o_alu_op    = ALU_SUM;
        o_pc_src    = 1'b0;
        o_fw_sel    = 1'b0;
        if (i_reset) begin
            // Look like FETCH while reset is held, but never commit PC/IR.
            o_mem_read  = 1'b1;
            o_alu_b_sel = 2'd1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_b_sel = 2'd1;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                end
                S_DECODE:    o_alu_b_sel = 2'd3;
                S_MEM_ADDR: begin
                    o_alu_a_sel = 1'b1;
                    o_alu_b_sel = 2'd2;
                end
                S_MEM_READ:  o_mem_read = 1'b1;
                S_WB_MEM: begin
                    o_reg_write = 1'b1;
                    o_fw_sel    = 1'b1;
                end
                S_MEM_WRITE: o_mem_write = 1'b1;
                S_EXEC_R: begin
                    o_alu_a_sel = 1'b1;
                    o_alu_op    = (i_funct3 == 3'b000 && i_funct7_5) ? ALU_SUB : w_mapped_op;
                end
                S_EXEC_I: begin
                    o_alu_a_sel = 1'b1;
                    o_alu_b_sel = 2'd2;
                    o_alu_op    = w_mapped_op;
                end
                S_EXEC_LUI: begin
                    o_alu_b_sel = 2'd2;
                    o_alu_op    = ALU_LOAD;
                end
                S_WB_ALU:    o_reg_write = 1'b1;
                S_BRANCH: begin
                    o_alu_a_sel = 1'b1;
                    o_alu_op    = ALU_SUB;
                    o_pc_src    = 1'b1;
                    o_pc_write  = (i_funct3 == 3'b000) ? i_alu_zero : !i_alu_zero;
                end
                default: ;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized instruction stream checked against a per-instruction path model
module tb_control_unit;

    localparam int WL = 15;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_a_sel, pc_src, fw_sel;
    logic [1:0] alu_b_sel, fault_code;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_fail = 0;
    int zmode = -1;

    typedef struct {
        int         st;
        logic       rdy;
        logic [1:0] fc;
    } step_t;
    step_t q[$];

    control_unit #(.WAIT_LIMIT(WL)) dut (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_alu_zero(alu_zero), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_write(reg_write),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_alu_a_sel(alu_a_sel),
        .o_alu_b_sel(alu_b_sel), .o_alu_op(alu_op), .o_pc_src(pc_src), .o_fw_sel(fw_sel),
        .o_state(state), .o_fault_code(fault_code)
    );

    always #5 clk = ~clk;

    wire [12:0] obs = {pc_write, ir_write, reg_write, mem_read, mem_write, alu_a_sel,
                       alu_b_sel, alu_op, pc_src, fw_sel};

    task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [2:0] op_of_f3(input logic [2:0] f3, input logic sub);
        logic [2:0] t;
        case (f3)
            3'd1:    t = 3'd1;
            3'd4:    t = 3'd4;
            3'd5:    t = 3'd5;
            3'd7:    t = 3'd7;
            default: t = sub ? 3'd2 : 3'd0;
        endcase
        return t;
    endfunction

    // Expected strobes for one cycle, written directly from the per-state output table.
    function automatic logic [12:0] exp_out(input int st, input logic rdy, input logic z,
                                            input logic [2:0] f3, input logic f7);
        logic pcw = 0, irw = 0, rw = 0, mr = 0, mw = 0, as = 0, ps = 0, fw = 0;
        logic [1:0] bs = 0;
        logic [2:0] op = 0;
        case (st)
            0:  begin mr = 1; bs = 1; pcw = rdy; irw = rdy; end
            1:  bs = 3;
            2:  begin as = 1; bs = 2; end
            3:  mr = 1;
            4:  begin rw = 1; fw = 1; end
            5:  mw = 1;
            6:  begin as = 1; op = op_of_f3(f3, f7); end
            7:  begin as = 1; bs = 2; op = op_of_f3(f3, 1'b0); end
            8:  begin bs = 2; op = 3; end
            9:  rw = 1;
            10: begin as = 1; op = 2; ps = 1; pcw = (f3 == 0) ? z : !z; end
            default: ;
        endcase
        return {pcw, irw, rw, mr, mw, as, bs, op, ps, fw};
    endfunction

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bit arith = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5) || (f3 == 7);
        case (op)
            7'b0110011: return (arith && (!f7 || f3 == 0)) ? K_R : K_ILL;
            7'b0010011: return arith ? K_I : K_ILL;
            7'b0110111: return K_LUI;
            7'b0000011: return (f3 == 2) ? K_LD : K_ILL;
            7'b0100011: return (f3 == 2) ? K_ST : K_ILL;
            7'b1100011: return (f3 <= 1) ? K_BR : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic void push(input int st, input logic rdy, input logic [1:0] fc);
        step_t s;
        s.st = st; s.rdy = rdy; s.fc = fc;
        q.push_back(s);
    endfunction

    // Memory-wait phase: returns 1 if the wait budget is exhausted and the path ends in FAULT.
    function automatic bit mem_phase(input int st, input int waits);
        if (waits >= WL) begin
            repeat (WL) push(st, 1'b0, 2'd0);
            repeat (5) push(15, 1'($urandom), 2'd2);
            return 1;
        end
        repeat (waits) push(st, 1'b0, 2'd0);
        push(st, 1'b1, 2'd0);
        return 0;
    endfunction

    function automatic bit build(input int fw, input int mw);
        int k = classify(opcode, funct3, funct7_5);
        q.delete();
        if (mem_phase(0, fw)) return 1;
        push(1, 1'($urandom), 2'd0);
        case (k)
            K_R:   begin push(6, 1'($urandom), 0); push(9, 1'($urandom), 0); end
            K_I:   begin push(7, 1'($urandom), 0); push(9, 1'($urandom), 0); end
            K_LUI: begin push(8, 1'($urandom), 0); push(9, 1'($urandom), 0); end
            K_LD: begin
                push(2, 1'($urandom), 0);
                if (mem_phase(3, mw)) return 1;
                push(4, 1'($urandom), 0);
            end
            K_ST: begin
                push(2, 1'($urandom), 0);
                if (mem_phase(5, mw)) return 1;
            end
            K_BR:  push(10, 1'($urandom), 0);
            default: begin
                repeat (10) push(15, 1'($urandom), 2'd1);
                return 1;
            end
        endcase
        return 0;
    endfunction

    task automatic run_queue(input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            mem_ready = q[i].rdy;
            alu_zero  = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            check("state", 16'(state), 16'(q[i].st));
            check("fault_code", 16'(fault_code), 16'(q[i].fc));
            check("outputs", 16'(obs), 16'(exp_out(q[i].st, q[i].rdy, alu_zero, funct3, funct7_5)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", 16'(obs), 16'(exp_out(0, 1'b0, 1'b0, 3'd0, 1'b0)));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_state", 16'(state), 16'd0);
        check("reset_fault", 16'(fault_code), 16'd0);
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input int fw, input int mw);
        bit faulted;
        opcode = op; funct3 = f3; funct7_5 = f7;
        faulted = build(fw, mw);
        run_queue(q.size());
        if (faulted) do_reset();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        instr(7'b0110011, 3'b000, 1'b0, 0, 0);
        instr(7'b0110011, 3'b000, 1'b1, 0, 0);
        instr(7'b0010011, 3'b101, 1'b0, 0, 0);
        instr(7'b0000011, 3'b010, 1'b0, 0, 3);
        instr(7'b0100011, 3'b010, 1'b0, 2, 1);
        instr(7'b0110111, 3'b011, 1'b0, 0, 0);
        zmode = 1;
        instr(7'b1100011, 3'b000, 1'b0, 0, 0);
        instr(7'b1100011, 3'b001, 1'b0, 0, 0);
        zmode = -1;
        instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        instr(7'b0110011, 3'b001, 1'b1, 0, 0);
        instr(7'b0110011, 3'b000, 1'b0, WL, 0);
        instr(7'b0110011, 3'b111, 1'b0, WL - 1, 0);
        instr(7'b0000011, 3'b010, 1'b0, 0, WL - 1);
        instr(7'b0100011, 3'b010, 1'b0, 0, WL);

        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        void'(build(0, 10));
        run_queue(5);
        do_reset();

        for (int n = 0; n < 200; n++) begin
            logic [6:0] ops [6];
            logic [6:0] op;
            logic [2:0] f3;
            int fw, mw;
            ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
            ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            f3 = 3'($urandom);
            if ((op == 7'b0000011 || op == 7'b0100011) && $urandom_range(0, 3) != 0) f3 = 3'b010;
            if (op == 7'b1100011 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) fw = WL;
            if ($urandom_range(0, 19) == 0) mw = ($urandom_range(0, 1) == 0) ? WL : WL - 1;
            instr(op, f3, 1'($urandom_range(0, 3) == 0), fw, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
